fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch and PC-sequencing stage that sits directly upstream of the control unit and drives its 32-bit INSTRUCTION input. It holds the program counter and handshakes with instruction memory. It keeps each fetched instruction stable for the whole execute phase, stalls while data memory is busy, and resolves jump and beq targets from the control unit's flags and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0600_0000, instruction driven while no valid fetch is held (j +0: no register write, no memory access)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
IMEM_READDATA  input  32  instruction word from instruction memory
IMEM_BUSYWAIT  input  1  high while instruction memory has not yet delivered IMEM_READDATA
IMEM_READ  output  1  instruction read request
IMEM_ADDRESS  output  32  fetch address (equals PC)
INSTRUCTION  output  32  held instruction, feeds the control unit
PC  output  32  address of the held instruction
PC_PLUS4  output  32  PC+4, combinational
JUMP_FLAG  input  1  from control unit
BRANCH_FLAG  input  1  from control unit
ZERO  input  1  ALU result == 0
DMEM_BUSYWAIT  input  1  data memory busy (lwd/lwi/swd/swi in progress)
COMMIT  output  1  one-cycle pulse at the edge where the held instruction retires; gates the register-file write

Behaviour:
- States: S_RESET, S_FETCH, S_EXEC, S_STALL. Encoding is free; one-hot or binary.
- Reset (RESET_N low, asynchronous, any state, including mid-fetch or mid-stall):
  - state=S_RESET, PC=RESET_PC, INSTRUCTION=NOP_INSTR
  - IMEM_READ=0, COMMIT=0
- S_RESET: after the first rising edge with RESET_N high, go to S_FETCH.
- S_FETCH:
  - Drives IMEM_READ=1 and IMEM_ADDRESS=PC.
  - On an edge with IMEM_BUSYWAIT=0: INSTRUCTION<=IMEM_READDATA, go to S_EXEC.
  - Otherwise remain in S_FETCH; INSTRUCTION holds its previous value.
  - A zero-wait memory (IMEM_BUSYWAIT low throughout) gives a 1-cycle fetch.
- S_EXEC:
  - IMEM_READ=0 and INSTRUCTION is held constant.
  - The control unit decodes within 1 ns; the clock period must be ≥8 ns so that flags, ALU and ZERO settle before the next edge.
  - On the next edge, if DMEM_BUSYWAIT=1, go to S_STALL; nothing is committed.
  - Otherwise perform the retire action and go to S_FETCH.
- S_STALL:
  - Holds everything.
  - On the first edge with DMEM_BUSYWAIT=0, perform the retire action and go to S_FETCH.
- Retire action:
  - COMMIT is high for exactly that one cycle (combinational in the retiring state when the exit condition holds).
  - PC<=next_pc.
- next_pc:
  - taken = JUMP_FLAG | (BRANCH_FLAG & ZERO)
  - offset = sign-extend(INSTRUCTION[23:16]) << 2 (signed word offset)
  - next_pc = taken ? PC_PLUS4 + offset : PC_PLUS4
  - All arithmetic is modulo 2^32: PC 0xFFFF_FFFC + 4 wraps to 0, and the target also wraps.
  - Flags are sampled only at the retire edge. Values during fetch or stall are ignored.
  - Flags that are x or z (undefined opcode) are treated as not taken: PC+4.
- Simultaneous events:
  - IMEM_BUSYWAIT in S_EXEC/S_STALL is ignored.
  - DMEM_BUSYWAIT in S_FETCH is ignored.
  - Reset overrides everything.
- PC_PLUS4 = PC+4 at all times.

Optional Feature:
Macro FETCH_RETIRE_COUNT_EN.
- Defined:
  - Adds output RETIRED (32 bits), cleared by reset, incremented by 1 on every COMMIT edge, wraps 0xFFFF_FFFF→0.
  - Adds output STALL_CYCLES (32 bits), cleared by reset, incremented on every edge spent in S_STALL or in S_FETCH with IMEM_BUSYWAIT=1, saturating at 0xFFFF_FFFF.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then zero-wait imem returning 0x0000_0105 (loadi) → INSTRUCTION=0x0000_0105 one edge after S_FETCH entry; COMMIT pulses once; PC 0→4→8 across two instructions; fetch-to-fetch period 2 cycles.
- IMEM_BUSYWAIT high 3 cycles at PC=8 → IMEM_READ high and INSTRUCTION unchanged for 3 cycles; instruction latched on the 4th edge.
- At PC=0x10, INSTRUCTION=0x06FE_0000 (j −2) with JUMP_FLAG=1 → next PC=0x14−8=0x0C. Same word with BRANCH_FLAG=1, ZERO=0, JUMP_FLAG=0 → next PC=0x14.
- beq 0x0703_0102 at PC=0x20 with BRANCH_FLAG=1, ZERO=1 → PC=0x24+12=0x30. PC=0xFFFF_FFFC, no branch → PC=0.
- lwd with DMEM_BUSYWAIT high 5 cycles → state S_STALL, no COMMIT, PC frozen; single COMMIT when busywait drops, then PC+4.
- RESET_N pulsed low mid-stall, asynchronously between edges → PC=RESET_PC, INSTRUCTION=0x0600_0000, IMEM_READ=0 immediately. With FETCH_RETIRE_COUNT_EN: RETIRED=0, STALL_CYCLES=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem handshake, control-unit flags and held-instruction bus of the fetch stage.
// Optional RETIRED/STALL_CYCLES signals exist only when FETCH_RETIRE_COUNT_EN is defined.
interface fetch_unit_if;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        JUMP_FLAG;
  logic        BRANCH_FLAG;
  logic        ZERO;
  logic        DMEM_BUSYWAIT;
  logic        COMMIT;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] RETIRED;
  logic [31:0] STALL_CYCLES;
  modport master (
    input  IMEM_READDATA, IMEM_BUSYWAIT, JUMP_FLAG, BRANCH_FLAG, ZERO, DMEM_BUSYWAIT,
    output IMEM_READ, IMEM_ADDRESS, INSTRUCTION, PC, PC_PLUS4, COMMIT, RETIRED, STALL_CYCLES
  );
  modport slave (
    output IMEM_READDATA, IMEM_BUSYWAIT, JUMP_FLAG, BRANCH_FLAG, ZERO, DMEM_BUSYWAIT,
    input  IMEM_READ, IMEM_ADDRESS, INSTRUCTION, PC, PC_PLUS4, COMMIT, RETIRED, STALL_CYCLES
  );
`else
  modport master (
    input  IMEM_READDATA, IMEM_BUSYWAIT, JUMP_FLAG, BRANCH_FLAG, ZERO, DMEM_BUSYWAIT,
    output IMEM_READ, IMEM_ADDRESS, INSTRUCTION, PC, PC_PLUS4, COMMIT
  );
  modport slave (
    output IMEM_READDATA, IMEM_BUSYWAIT, JUMP_FLAG, BRANCH_FLAG, ZERO, DMEM_BUSYWAIT,
    input  IMEM_READ, IMEM_ADDRESS, INSTRUCTION, PC, PC_PLUS4, COMMIT
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch/hold ahead of the control unit.
// Define FETCH_RETIRE_COUNT_EN to add the RETIRED and STALL_CYCLES counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0600_0000
) (
  input logic          CLK,
  input logic          RESET_N,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC, S_STALL} state_t;
  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr, w_offset, w_next_pc;
  logic        w_taken, w_retire, w_fetch_done;
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET: w_next_state = S_FETCH;
      S_FETCH: w_next_state = bus.IMEM_BUSYWAIT ? S_FETCH : S_EXEC;
      default: w_next_state = bus.DMEM_BUSYWAIT ? S_STALL : S_FETCH;
    endcase
  end
  assign w_fetch_done = (r_state == S_FETCH) && !bus.IMEM_BUSYWAIT;
  assign w_retire     = (r_state == S_EXEC || r_state == S_STALL) && !bus.DMEM_BUSYWAIT;
  // undefined (x/z) flags never select the branch target
  assign w_taken   = (bus.JUMP_FLAG === 1'b1) || ((bus.BRANCH_FLAG === 1'b1) && (bus.ZERO === 1'b1));
  assign w_offset  = {{22{r_instr[23]}}, r_instr[23:16], 2'b00};
  assign w_next_pc = w_taken ? bus.PC_PLUS4 + w_offset : bus.PC_PLUS4;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_RESET;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_done) r_instr <= bus.IMEM_READDATA;
      if (w_retire) r_pc <= w_next_pc;
    end
  end
  assign bus.IMEM_READ    = (r_state == S_FETCH);
  assign bus.IMEM_ADDRESS = r_pc;
  assign bus.INSTRUCTION  = r_instr;
  assign bus.PC           = r_pc;
  assign bus.PC_PLUS4     = r_pc + 32'd4;
  assign bus.COMMIT       = w_retire;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] r_retired, r_stall_cycles;
  logic        w_stall_edge;
  assign w_stall_edge = (r_state == S_STALL) || ((r_state == S_FETCH) && bus.IMEM_BUSYWAIT);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_retired      <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_retire) r_retired <= r_retired + 32'd1;
      if (w_stall_edge && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
  assign bus.RETIRED      = r_retired;
  assign bus.STALL_CYCLES = r_stall_cycles;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch/execute traffic; a monitor checks each COMMIT against a
// queue of expected retirements computed from the PC-sequencing rules.
module tb_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] nxt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0600_0000;
  logic [31:0] exp_retired = 0;
  logic [31:0] exp_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic junk();
    bus.JUMP_FLAG     = 1'($urandom);
    bus.BRANCH_FLAG   = 1'($urandom);
    bus.ZERO          = 1'($urandom);
    bus.IMEM_READDATA = $urandom;
  endtask

  task automatic chk_counters();
`ifdef FETCH_RETIRE_COUNT_EN
    chk("retired", bus.RETIRED, exp_retired);
    chk("stall_cycles", bus.STALL_CYCLES, exp_stall);
`endif
  endtask

  // Called at negedge+1 with the unit in (or about to enter) S_FETCH; returns at negedge+1 in S_FETCH.
  task automatic run_instr(input logic [31:0] w, input int iw, input bit j, input bit b, input bit z,
                           input int dw);
    int          n = 0;
    int          off;
    logic [31:0] nxt;
    while (bus.IMEM_READ !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("fetch_req", 32'(bus.IMEM_READ), 32'd1);
    chk("imem_addr", bus.IMEM_ADDRESS, m_pc);
    repeat (iw) begin
      junk();
      bus.IMEM_BUSYWAIT = 1'b1;
      bus.DMEM_BUSYWAIT = 1'($urandom);
      @(negedge clk); #1;
      chk("fetch_wait_read", 32'(bus.IMEM_READ), 32'd1);
      chk("fetch_wait_instr", bus.INSTRUCTION, m_instr);
    end
    junk();
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.IMEM_READDATA = w;
    bus.DMEM_BUSYWAIT = (dw > 0);
    @(negedge clk); #1;
    chk("exec_instr", bus.INSTRUCTION, w);
    chk("exec_read", 32'(bus.IMEM_READ), 32'd0);
    repeat (dw) begin
      junk();
      bus.IMEM_BUSYWAIT = 1'($urandom);
      bus.DMEM_BUSYWAIT = 1'b1;
      @(negedge clk); #1;
      chk("stall_pc", bus.PC, m_pc);
      chk("stall_commit", 32'(bus.COMMIT), 32'd0);
      chk("stall_instr", bus.INSTRUCTION, w);
    end
    off = 4 * int'($signed(w[23:16]));
    nxt = m_pc + 32'd4 + ((j || (b && z)) ? 32'(off) : 32'd0);
    q.push_back('{pc: m_pc, instr: w, nxt: nxt});
    bus.JUMP_FLAG     = j;
    bus.BRANCH_FLAG   = b;
    bus.ZERO          = z;
    bus.DMEM_BUSYWAIT = 1'b0;
    bus.IMEM_BUSYWAIT = 1'b1;
    @(negedge clk); #1;
    m_pc    = nxt;
    m_instr = w;
    exp_retired++;
    exp_stall += 32'(iw + dw);
    chk("refetch", 32'(bus.IMEM_READ), 32'd1);
    chk("next_pc", bus.PC, nxt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (bus.COMMIT === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 32'(bus.COMMIT), 32'd0);
        end else begin
          e = q.pop_front();
          chk("commit_pc", bus.PC, e.pc);
          chk("commit_instr", bus.INSTRUCTION, e.instr);
          @(posedge clk); #1;
          chk("retired_pc", bus.PC, e.nxt);
          chk("pc_plus4", bus.PC_PLUS4, e.nxt + 32'd4);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bus.IMEM_READDATA = 0;
    bus.IMEM_BUSYWAIT = 0;
    bus.JUMP_FLAG     = 0;
    bus.BRANCH_FLAG   = 0;
    bus.ZERO          = 0;
    bus.DMEM_BUSYWAIT = 0;
    #12;
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_instr", bus.INSTRUCTION, 32'h0600_0000);
    chk("rst_read", 32'(bus.IMEM_READ), 32'd0);
    chk("rst_commit", 32'(bus.COMMIT), 32'd0);
    chk("rst_pc_plus4", bus.PC_PLUS4, 32'h4);
    chk_counters();
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_instr(32'h0000_0105, 0, 0, 0, 0, 0);
    chk("loadi_pc", bus.PC, 32'h4);
    run_instr(32'h0000_0105, 0, 0, 0, 0, 0);
    chk("second_pc", bus.PC, 32'h8);
    run_instr(32'h1111_0000, 3, 0, 0, 0, 0);
    run_instr(32'h0000_0000, 0, 0, 0, 0, 0);
    chk("pc_at_10", bus.PC, 32'h10);
    run_instr(32'h06FE_0000, 0, 1, 0, 0, 0);
    chk("jump_back", bus.PC, 32'h0C);
    run_instr(32'h06FE_0000, 0, 0, 1, 0, 0);
    chk("beq_not_taken", bus.PC, 32'h10);
    run_instr(32'h0000_0000, 1, 0, 0, 0, 0);
    run_instr(32'h0702_0000, 0, 1, 0, 0, 0);
    chk("jump_fwd", bus.PC, 32'h20);
    run_instr(32'h0703_0102, 0, 0, 1, 1, 0);
    chk("beq_taken", bus.PC, 32'h30);
    run_instr(32'h0000_0000, 0, 0, 0, 0, 5);
    chk("lwd_stall_pc", bus.PC, 32'h34);
    chk_counters();
    for (int i = 0; i < 60; i++)
      run_instr($urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom),
                1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
    chk_counters();
    bus.IMEM_BUSYWAIT = 1'b0;
    bus.IMEM_READDATA = 32'h1234_5678;
    bus.DMEM_BUSYWAIT = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("pre_reset_stall_pc", bus.PC, m_pc);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #2;
    chk("async_rst_pc", bus.PC, 32'h0);
    chk("async_rst_instr", bus.INSTRUCTION, 32'h0600_0000);
    chk("async_rst_read", 32'(bus.IMEM_READ), 32'd0);
    chk("async_rst_commit", 32'(bus.COMMIT), 32'd0);
    m_pc        = 32'h0;
    m_instr     = 32'h0600_0000;
    exp_retired = 0;
    exp_stall   = 0;
    chk_counters();
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus.DMEM_BUSYWAIT = 1'b0;
    run_instr(32'h06FE_0000, 0, 1, 0, 0, 0);
    chk("wrap_target", bus.PC, 32'hFFFF_FFFC);
    run_instr(32'h0000_0105, 2, 0, 1, 0, 1);
    chk("wrap_plus4", bus.PC, 32'h0);
    for (int i = 0; i < 10; i++)
      run_instr($urandom, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)));
    chk_counters();
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
